fb_ram_arbiter: RTL and testbench

//  Shares the single-port framebuffer RAM (12-bit colour words, 15-bit address)

---
 rtl/fb_pkg.sv | 14 +
 rtl/fb_ram_arbiter_rr_pick.sv | 28 ++
 rtl/fb_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_fb_ram_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants: colour/address widths, requester indices and arbiter state type.
package fb_pkg;
    localparam int CBIT       = 11;
    localparam int AW         = 15;
    localparam int CW         = CBIT + 1;
    localparam int REQ_LOGIC  = 0;
    localparam int REQ_SPRITE = 1;
    localparam int REQ_VGA    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;
endpackage

// File: rtl/fb_ram_arbiter_rr_pick.sv
// Rotate-priority encoder: first requester at or above ptr (modulo N) wins.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);
    logic [PW-1:0] w_idx;

    // Scan from ptr upward with wrap; the first hit masks all later candidates.
    always_comb begin
        win   = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!valid && req[w_idx]) begin
                win[w_idx] = 1'b1;
                valid      = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end
endmodule

// File: rtl/fb_ram_arbiter.sv
// Round-robin framebuffer RAM arbiter with bounded burst lock and tagged read return.
module fb_ram_arbiter
    import fb_pkg::*;
#(
    parameter int CBIT_P    = CBIT,
    parameter int AW_P      = AW,
    parameter int N_REQ     = 3,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*AW_P-1:0]     addr_in,
    input  logic [N_REQ*(CBIT_P+1)-1:0] wdata_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [CBIT_P:0]           rdata,
    output logic [AW_P-1:0]           ram_addr,
    output logic [CBIT_P:0]           ram_data,
    output logic                      ram_wren,
    input  logic [CBIT_P:0]           ram_q,
    output logic                      busy
);
    localparam int PW  = $clog2(N_REQ);
    localparam int BCW = $clog2(BURST_MAX + 1);
    localparam logic [BCW-1:0] BMAX = BCW'(BURST_MAX);

    arb_state_t       r_state;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [BCW-1:0]   r_bcnt;
    logic [N_REQ-1:0] r_tag [RD_LAT];

    logic [N_REQ-1:0] w_own_oh;
    logic [PW-1:0]    w_owner_nx;
    logic [PW-1:0]    w_search_ptr;
    logic             w_keep;
    logic [N_REQ-1:0] w_pick;
    logic             w_pick_v;
    logic [PW-1:0]    w_pick_idx;
    logic [N_REQ-1:0] w_gnt;
    logic             w_tag_any;

    assign w_own_oh     = N_REQ'(1) << r_owner;
    assign w_owner_nx   = (r_owner == PW'(N_REQ - 1)) ? PW'(0) : r_owner + PW'(1);
    assign w_search_ptr = (r_state == ST_OWN) ? w_owner_nx : r_ptr;
    // Owner holds the bus until it drops req, or its burst expires while someone else waits.
    assign w_keep = (r_state == ST_OWN) && req[r_owner] &&
                    ((r_bcnt < BMAX) || ((req & ~w_own_oh) == '0));

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (w_search_ptr),
        .win   (w_pick),
        .valid (w_pick_v)
    );

    // Grant selection, winner index and RAM port mux.
    always_comb begin
        if (!resetn || !enable) begin
            w_gnt = '0;
        end else if (w_keep) begin
            w_gnt = w_own_oh;
        end else begin
            w_gnt = w_pick;
        end
        w_pick_idx = '0;
        ram_addr   = '0;
        ram_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PW'(i);
            end else begin
                w_pick_idx = w_pick_idx;
            end
            if (w_gnt[i]) begin
                ram_addr = addr_in[i*AW_P +: AW_P];
                ram_data = wdata_in[i*(CBIT_P+1) +: (CBIT_P+1)];
            end else begin
                ram_addr = ram_addr;
            end
        end
    end

    assign gnt      = w_gnt;
    assign ram_wren = |(w_gnt & req & we);
    assign rvalid   = r_tag[RD_LAT-1];
    assign rdata    = ram_q;

    // Any read still travelling through the tag pipeline keeps the block busy.
    always_comb begin
        w_tag_any = 1'b0;
        for (int s = 0; s < RD_LAT; s++) begin
            w_tag_any = w_tag_any | (|r_tag[s]);
        end
    end

    assign busy = (r_state == ST_OWN) | w_tag_any;

    // Arbitration FSM, burst counter and read-tag shift register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_bcnt  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_gnt & req & ~we;
            for (int s = 1; s < RD_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            if (enable) begin
                if (w_keep) begin
                    r_bcnt <= (r_bcnt < BMAX) ? r_bcnt + BCW'(1) : r_bcnt;
                end else if (w_pick_v) begin
                    r_state <= ST_OWN;
                    r_owner <= w_pick_idx;
                    r_bcnt  <= BCW'(1);
                    r_ptr   <= w_search_ptr;
                end else begin
                    r_state <= ST_IDLE;
                    r_ptr   <= w_search_ptr;
                end
            end else begin
                r_state <= r_state;
            end
        end
    end
endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Randomized bench for fb_ram_arbiter against a behavioural arbitration/RAM model.
module tb_fb_ram_arbiter;
    localparam int N = 3;
    localparam int AWB = 15;
    localparam int CWB = 12;
    localparam int LAT = 1;
    localparam int BM = 16;

    logic clock = 1'b0;
    logic resetn, enable;
    logic [N-1:0] req, we, gnt, rvalid;
    logic [N*AWB-1:0] addr_in;
    logic [N*CWB-1:0] wdata_in;
    logic [CWB-1:0] rdata, ram_data, ram_q;
    logic [AWB-1:0] ram_addr;
    logic ram_wren, busy;

    fb_ram_arbiter dut (
        .clock(clock), .resetn(resetn), .enable(enable), .req(req), .we(we),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    always #5 clock = ~clock;

    // RAM macro stand-in: one-cycle registered read, new data on read-after-write.
    logic [CWB-1:0] mem [0:32767];
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= ram_wren ? ram_data : mem[ram_addr];
    end

    typedef struct { int due; int who; logic [CWB-1:0] data; } rd_t;
    rd_t pend[$];
    logic [CWB-1:0] mdl_mem [int];
    int m_owner, m_cnt, m_ptr, cyc;
    int n_vec = 0, n_err = 0;
    int last_win, idle_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CWB-1:0] mem_rd(input int a);
        return mdl_mem.exists(a) ? mdl_mem[a] : '0;
    endfunction

    // Who should own the RAM this cycle, from the arbitration rules alone.
    function automatic int model_pick();
        int start;
        int others;
        if (!resetn || !enable) return -1;
        if (m_owner >= 0 && req[m_owner]) begin
            others = 0;
            for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1;
            if (m_cnt < BM || others == 0) return m_owner;
        end
        start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++) if (req[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic step();
        int win, a;
        logic [N-1:0] eg, erv;
        logic [CWB-1:0] d;
        #1;
        win = model_pick();
        last_win = win;
        eg = (win >= 0) ? N'(1 << win) : '0;
        erv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) erv = N'(1 << pend[0].who);
        check("gnt", 32'(gnt), 32'(eg));
        check("rvalid", 32'(rvalid), 32'(erv));
        if (erv != '0) check("rdata", 32'(rdata), 32'(pend[0].data));
        check("busy", 32'(busy), 32'(m_owner >= 0 || pend.size() > 0));
        a = (win >= 0) ? int'(addr_in[win*AWB +: AWB]) : 0;
        d = (win >= 0) ? wdata_in[win*CWB +: CWB] : '0;
        check("ram_wren", 32'(ram_wren), 32'((win >= 0) ? we[win] : 1'b0));
        check("ram_addr", 32'(ram_addr), 32'(a));
        check("ram_data", 32'(ram_data), 32'(d));
        @(posedge clock);
        if (erv != '0) void'(pend.pop_front());
        if (!resetn) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; pend.delete();
        end else if (enable) begin
            if (win >= 0) begin
                if (we[win]) mdl_mem[a] = d;
                else pend.push_back('{due: cyc + LAT, who: win, data: mem_rd(a)});
                if (win == m_owner) m_cnt = (m_cnt < BM) ? m_cnt + 1 : m_cnt;
                else begin
                    if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                    m_owner = win; m_cnt = 1;
                end
            end else begin
                if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic set_port(input int i, input logic [AWB-1:0] a, input logic [CWB-1:0] d);
        addr_in[i*AWB +: AWB] = a;
        wdata_in[i*CWB +: CWB] = d;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        m_owner = -1; m_cnt = 0; m_ptr = 0; cyc = 0;
        resetn = 1'b0; enable = 1'b1; req = 3'b111; we = 3'b000;
        addr_in = '0; wdata_in = '0;
        @(negedge clock);
        step(); step();
        // Release with everybody requesting: requester 0 first.
        resetn = 1'b1;
        step();
        check("t1_first_gnt", 32'(last_win), 32'(0));
        req = 3'b000; step();

        // Write then read the same address from two requesters.
        set_port(1, 15'h0123, 12'hF00);
        req = 3'b010; we = 3'b010; step();
        set_port(2, 15'h0123, 12'h000);
        req = 3'b100; we = 3'b000; step();
        #1;
        check("t2_rvalid", 32'(rvalid), 32'(3'b100));
        check("t2_rdata", 32'(rdata), 32'(12'hF00));
        req = 3'b000; step();

        // All three held: round-robin in 16-beat bursts with no idle handover.
        resetn = 1'b0; step(); resetn = 1'b1;
        req = 3'b111; we = 3'b000; idle_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (last_win < 0) idle_cnt++;
            if (c == 15 || c == 16 || c == 32 || c == 48)
                check("t3_owner", 32'(last_win), 32'((c == 15) ? 0 : (c == 16) ? 1 : (c == 32) ? 2 : 0));
        end
        check("t3_no_idle", 32'(idle_cnt), 32'(0));
        req = 3'b000; step();

        // Lone requester keeps the bus beyond the burst limit.
        req = 3'b100; idle_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (last_win != 2) idle_cnt++;
        end
        check("t4_held", 32'(idle_cnt), 32'(0));
        req = 3'b000; step();

        // Disable mid-burst with a read in flight, then resume.
        set_port(0, 15'h0123, 12'h0);
        req = 3'b001; we = 3'b000; step(); step();
        enable = 1'b0; req = 3'b011; step(); step(); step();
        enable = 1'b1; step(); step();
        req = 3'b000; step();

        // Reset right after a read is accepted: the read never returns.
        req = 3'b001; step();
        req = 3'b000; resetn = 1'b0; step();
        resetn = 1'b1; step();
        req = 3'b110; step();
        check("t6_ptr0_winner", 32'(last_win), 32'(1));
        req = 3'b000; step();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            req = 3'($urandom_range(0, 7));
            we = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 15) != 0);
            resetn = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++)
                set_port(i, 15'($urandom_range(0, 7)), 12'($urandom));
            step();
        end
        resetn = 1'b1; enable = 1'b1; req = 3'b000;
        for (int c = 0; c < 4; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
